// File: rtl/stereo_sample_scheduler.sv
// Audio frame-rate scheduler: picks the test tone or the external stereo source once per frame and hands a stereo frame downstream.
// Optional SCHED_STATS_EN adds saturating overrun/timeout event counters.
module stereo_sample_scheduler #(
    parameter int CLK_HZ  = 240000000,
    parameter int FS_HZ   = 32000,
    parameter int DIV     = CLK_HZ / FS_HZ,
    parameter int SRC_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_i,
    input  logic        mute_i,
    output logic        tone_en_o,
    input  logic [15:0] tone_data_i,
    output logic        ext_req_o,
    input  logic        ext_ack_i,
    input  logic [15:0] ext_l_i,
    input  logic [15:0] ext_r_i,
    output logic        frame_valid_o,
    input  logic        frame_ready_i,
    output logic [15:0] frame_l_o,
    output logic [15:0] frame_r_o,
    output logic        overrun_o,
    output logic        timeout_o
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] overrun_cnt_o,
    output logic [15:0] timeout_cnt_o
`endif
);

    // state     | meaning
    // IDLE      | waiting for the frame tick
    // TONE_REQ  | one-cycle enable to the tone generator
    // TONE_WAIT | waiting SRC_LAT cycles for tone_data
    // EXT_REQ   | requesting an external sample, bounded by TIMEOUT
    // LOAD      | publish captured samples as the output frame

    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WMAX   = (SRC_LAT > TIMEOUT) ? SRC_LAT : TIMEOUT;
    localparam int WAIT_W = $clog2(WMAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [WAIT_W-1:0] TONE_LOAD = WAIT_W'(SRC_LAT - 1);
    localparam logic [WAIT_W-1:0] EXT_LOAD  = WAIT_W'(TIMEOUT - 1);

    if (SRC_LAT < 1 || TIMEOUT < 1) begin : g_bad_lat
        $fatal(1, "stereo_sample_scheduler: SRC_LAT and TIMEOUT must be at least 1");
    end
    // A frame must always finish before the next tick arrives.
    if (SRC_LAT + TIMEOUT + 4 >= DIV) begin : g_bad_div
        $fatal(1, "stereo_sample_scheduler: SRC_LAT+TIMEOUT+4 must be below DIV");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TONE_REQ,
        ST_TONE_WAIT,
        ST_EXT_REQ,
        ST_LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [15:0]         cap_l_q, cap_l_d;
    logic [15:0]         cap_r_q, cap_r_d;
    logic [15:0]         frame_l_q, frame_l_d;
    logic [15:0]         frame_r_q, frame_r_d;
    logic                frame_valid_q, frame_valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                tick;
    logic                load;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wait_q        <= '0;
            cap_l_q       <= '0;
            cap_r_q       <= '0;
            frame_l_q     <= '0;
            frame_r_q     <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            cap_l_q       <= cap_l_d;
            cap_r_q       <= cap_r_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cap_l_d   = cap_l_q;
        cap_r_d   = cap_r_q;
        timeout_d = 1'b0;
        tone_en_o = 1'b0;
        ext_req_o = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (sel_i) begin
                        state_d = ST_EXT_REQ;
                        wait_d  = EXT_LOAD;
                    end else begin
                        state_d = ST_TONE_REQ;
                    end
                end
            end
            ST_TONE_REQ: begin
                tone_en_o = 1'b1;
                wait_d    = TONE_LOAD;
                state_d   = ST_TONE_WAIT;
            end
            ST_TONE_WAIT: begin
                if (wait_q == '0) begin
                    cap_l_d = tone_data_i;
                    cap_r_d = tone_data_i;
                    state_d = ST_LOAD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_EXT_REQ: begin
                ext_req_o = 1'b1;
                // An ack in the final allowed cycle still wins over the timeout.
                if (ext_ack_i) begin
                    cap_l_d = ext_l_i;
                    cap_r_d = ext_r_i;
                    state_d = ST_LOAD;
                end else if (wait_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        frame_l_d     = frame_l_q;
        frame_r_d     = frame_r_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = 1'b0;

        if (load) begin
            frame_l_d     = mute_i ? 16'h0000 : cap_l_q;
            frame_r_d     = mute_i ? 16'h0000 : cap_r_q;
            frame_valid_d = 1'b1;
            overrun_d     = frame_valid_q & ~frame_ready_i;
        end else if (frame_valid_q && frame_ready_i) begin
            frame_valid_d = 1'b0;
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign frame_l_o     = frame_l_q;
    assign frame_r_o     = frame_r_q;
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;

`ifdef SCHED_STATS_EN
    logic [15:0] ovr_cnt_q;
    logic [15:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (overrun_q && (ovr_cnt_q != 16'hFFFF)) begin
                ovr_cnt_q <= ovr_cnt_q + 1'b1;
            end
            if (timeout_q && (to_cnt_q != 16'hFFFF)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
    assign timeout_cnt_o = to_cnt_q;
`else
    // Without statistics, overrun_o and timeout_o pulses are the only event reports.
`endif

endmodule
